krz_gpio_ctrl: RTL and testbench

Wishbone-controlled GPIO input controller for the KRZ platform. It synchronises 16 raw input pins and samples them on a programmable prescaler tick, accepting a new level only after three identical consecutive samples. It detects rising and falling edges on the accepted levels and latches them into a write-1-to-clear interrupt status register. It sits on the KRZ peripheral bus next to the GPIO pads and drives one level interrupt line to the core.

---
 rtl/krz_gpio_ctrl.sv | 130 +++++++++++++
 tb/tb_krz_gpio_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/krz_gpio_ctrl.sv
// KRZ GPIO input controller: 2-flop sync, prescaled 3-sample debounce,
// edge capture into W1C status, Wishbone register slave.
module krz_gpio_ctrl #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] gpio_in,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq
);

    localparam logic [15:0] PRESCALE_RST = PRESCALE[15:0];

    logic [15:0] s1_q, s1_d, s2_q, s2_d;
    logic [15:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [15:0] status_q, status_d;
    logic [15:0] prescale_q, prescale_d, cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        tick, acc, wr, rd;
    logic [2:0]  sel;
    logic [15:0] same, rise, fall;

    always_comb begin
        tick = (cnt_q == prescale_q);
        acc  = wb_stb_i && !ack_q;
        wr   = acc && wb_we_i;
        rd   = acc && !wb_we_i;
        sel  = wb_adr_i[4:2];

        s1_d       = gpio_in;
        s2_d       = s1_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        h2_d       = h2_q;
        data_d     = data_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        prescale_d = prescale_q;
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        ack_d      = acc;
        dat_d      = dat_q;
        same       = ~(h0_q ^ h1_q) & ~(h1_q ^ h2_q);

        if (tick) begin
            h0_d   = s2_q;
            h1_d   = h0_q;
            h2_d   = h1_q;
            data_d = (same & h0_q) | (~same & data_q);
        end

        // Enables are the pre-edge values, so a write never sets STATUS retroactively
        rise     = data_d & ~data_q & rise_en_q;
        fall     = ~data_d & data_q & fall_en_q;
        status_d = status_q;

        if (wr) begin
            case (sel)
                3'd1: rise_en_d = wb_dat_i[15:0];
                3'd2: fall_en_d = wb_dat_i[15:0];
                3'd3: status_d = status_q & ~wb_dat_i[15:0];
                3'd4: begin
                    prescale_d = wb_dat_i[15:0];
                    cnt_d      = 16'd0;
                end
                default: ;
            endcase
        end

        // New edges are OR-ed in after the clear so a same-edge set wins
        status_d = status_d | rise | fall;

        if (rd) begin
            case (sel)
                3'd0:    dat_d = {16'd0, data_q};
                3'd1:    dat_d = {16'd0, rise_en_q};
                3'd2:    dat_d = {16'd0, fall_en_q};
                3'd3:    dat_d = {16'd0, status_q};
                3'd4:    dat_d = {16'd0, prescale_q};
                default: dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
            h2_q       <= '0;
            data_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            prescale_q <= PRESCALE_RST;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            data_q     <= data_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_krz_gpio_ctrl.sv
// Scoreboard bench for krz_gpio_ctrl: bus reads queue expectations,
// a negedge monitor pops and compares on every ack.
module tb_krz_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] gpio_in;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    logic ack_prev = 1'b0;

    krz_gpio_ctrl #(.PRESCALE(1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_in  (gpio_in),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Monitor: every ack consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (wb_ack_o === 1'b1) begin
            checks++;
            if (ack_prev === 1'b1) begin
                errors++;
                $display("FAIL ack_width: ack high 2 cycles in a row, required 1");
            end
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack with empty scoreboard");
            end else begin
                e = sbq.pop_front();
                if (e.chk) begin
                    checks++;
                    if (wb_dat_o !== e.exp) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h",
                                 e.name, wb_dat_o, e.exp);
                    end
                end
            end
        end
        ack_prev = wb_ack_o;
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic bus(input int lead, input bit we, input logic [2:0] idx,
                       input logic [31:0] d, input bit c,
                       input logic [31:0] exp, input string n);
        exp_t e;
        int   cyc;
        e.chk  = c;
        e.exp  = exp;
        e.name = n;
        repeat (lead) @(negedge clk);
        sbq.push_back(e);
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {idx, idx[1:0]};
        wb_dat_i = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (wb_ack_o !== 1'b1 && cyc < 8);
        if (wb_ack_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack in %0d cycles", n, cyc);
            void'(sbq.pop_back());
        end
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        bus(1, 1'b1, idx, d, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp,
                      input string n);
        bus(1, 1'b0, idx, 32'd0, 1'b1, exp, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst      = 1'b1;
        gpio_in  = '0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // Reset defaults on all eight words
        rd(0, 32'd0, "rst_data");
        rd(1, 32'd0, "rst_rise_en");
        rd(2, 32'd0, "rst_fall_en");
        rd(3, 32'd0, "rst_status");
        rd(4, 32'd1000, "rst_prescale");
        rd(5, 32'd0, "rst_word5");
        rd(6, 32'd0, "rst_word6");
        rd(7, 32'd0, "rst_word7");
        wr(0, 32'hFFFF);
        rd(0, 32'd0, "data_ro");

        // Latency and rising edge at PRESCALE=0
        wr(4, 32'd0);
        wr(1, 32'h0001);
        rd(1, 32'h0001, "rise_en_rb");
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("lat_irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("lat_irq_edge6", {31'd0, irq}, 32'd1);
        rd(3, 32'h0001, "status_rise");
        rd(0, 32'h0001, "data_rise");
        wr(3, 32'h0001);
        chk("w1c_irq_ack", {31'd0, irq}, 32'd0);
        rd(3, 32'h0000, "status_w1c");

        // Glitch rejection
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (2) @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd(0, 32'h0001, "glitch2_rejected");
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (2) @(negedge clk);
        rd(0, 32'h0009, "pulse3_accepted");
        repeat (10) @(negedge clk);
        rd(0, 32'h0001, "pulse3_released");
        rd(3, 32'h0000, "pulse3_no_status");

        // Prescaler spacing and falling edges
        gpio_in = 16'hFFFF;
        repeat (10) @(negedge clk);
        rd(0, 32'hFFFF, "all_high");
        wr(2, 32'hFFFF);
        wr(4, 32'd9);
        cyc = 0;
        while (dut.tick !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (dut.tick !== 1'b1 && cyc < 20);
            chk("tick_gap", cyc, 32'd10);
        end
        @(negedge clk);
        gpio_in = 16'h00FF;
        repeat (42) @(posedge clk);
        #1;
        chk("fall_irq_42", {31'd0, irq}, 32'd1);
        rd(0, 32'h00FF, "data_00ff");
        rd(3, 32'hFF00, "status_ff00");

        // Set/clear collision on bit 5
        wr(4, 32'd0);
        wr(3, 32'hFFFF);
        rd(3, 32'h0000, "pre_collision");
        @(negedge clk);
        gpio_in = 16'h00DF;
        bus(5, 1'b1, 3'd3, 32'h0020, 1'b0, 32'd0, "w1c_collide");
        rd(3, 32'h0020, "collision_set_wins");
        chk("collision_irq", {31'd0, irq}, 32'd1);

        // Mid-operation reset
        wr(1, 32'hFFFF);
        gpio_in = 16'h0000;
        repeat (10) @(negedge clk);
        gpio_in = 16'hFFFF;
        repeat (10) @(negedge clk);
        rd(3, 32'hFFFF, "status_all");
        @(negedge clk);
        gpio_in = 16'h0000;
        @(negedge clk);
        rst      = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 5'd12;
        @(negedge clk);
        chk("mid_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst      = 1'b0;
        wb_stb_i = 1'b0;
        repeat (10) @(negedge clk);
        rd(0, 32'd0, "post_rst_data");
        rd(1, 32'd0, "post_rst_rise_en");
        rd(2, 32'd0, "post_rst_fall_en");
        rd(3, 32'd0, "post_rst_status");
        rd(4, 32'd1000, "post_rst_prescale");
        chk("post_rst_irq", {31'd0, irq}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
